// File: rtl/p2s_out_if.sv
// p2s_out_if: result-in / beat-out bus between the encdec stage, p2s_out and the downstream sink
interface p2s_out_if #(
    parameter int OUT_W = 32
);
    logic               din_valid;
    logic [127:0]       din;
    logic               hold_o;
    logic               dout_valid;
    logic [OUT_W-1:0]   dout;
    logic               dout_last;
    logic               p2s_fifo_almost_full;
    logic               p2s_fifo_full;
    logic               overflow;

    modport master (
        output din_valid, din, hold_o,
        input  dout_valid, dout, dout_last, p2s_fifo_almost_full, p2s_fifo_full, overflow
    );

    modport slave (
        input  din_valid, din, hold_o,
        output dout_valid, dout, dout_last, p2s_fifo_almost_full, p2s_fifo_full, overflow
    );
endinterface

// File: rtl/p2s_out.sv
// p2s_out: 128-bit result FIFO feeding an MSB-first OUT_W-bit serializer with hold back-pressure
module p2s_out #(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int OUT_W     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    p2s_out_if.slave    bus
);
    localparam int BEATS = 128 / OUT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(BEATS);

    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] BEAT_ONE = CW'(1);
    localparam logic [CW-1:0] BEAT_PEN = CW'(BEATS - 2);

    typedef enum logic {IDLE, SEND} state_t;

    logic [127:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     occ_q, occ_d;
    logic            overflow_q;
    state_t          state_q;
    logic [127:0]    shift_q;
    logic [CW-1:0]   beat_q;
    logic            dout_valid_q, dout_last_q;
    logic            wr_en, xfer, pop;

    // A write is accepted only against the registered occupancy, so a same-cycle pop never makes room.
    always_comb begin
        wr_en = bus.din_valid && (occ_q != OCC_FULL);
        xfer  = dout_valid_q && !bus.hold_o;
        pop   = (occ_q != '0) && ((state_q == IDLE) || (xfer && dout_last_q));
        occ_d = (wr_en && !pop) ? occ_q + OCC_ONE :
                (!wr_en && pop) ? occ_q - OCC_ONE : occ_q;
    end

    assign bus.dout                 = shift_q[127 -: OUT_W];
    assign bus.dout_valid           = dout_valid_q;
    assign bus.dout_last            = dout_last_q;
    assign bus.p2s_fifo_almost_full = occ_q >= OCC_AF;
    assign bus.p2s_fifo_full        = occ_q == OCC_FULL;
    assign bus.overflow             = overflow_q;

    // Storage array carries no reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.din;
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            occ_q      <= occ_d;
            overflow_q <= overflow_q || (bus.din_valid && !wr_en);
        end
    end

    // Serializer FSM: load a block, shift out one beat per unheld cycle, chain straight into the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            beat_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else if (pop) begin
            state_q      <= SEND;
            shift_q      <= mem_q[rd_ptr_q];
            beat_q       <= '0;
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
        end else if (state_q == SEND && xfer) begin
            if (!dout_last_q) begin
                shift_q     <= shift_q << OUT_W;
                beat_q      <= beat_q + BEAT_ONE;
                dout_last_q <= beat_q == BEAT_PEN;
            end else begin
                state_q      <= IDLE;
                shift_q      <= '0;
                beat_q       <= '0;
                dout_valid_q <= 1'b0;
                dout_last_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_p2s_out.sv
// tb_p2s_out: scoreboard bench for p2s_out with directed scenarios and randomized traffic
module tb_p2s_out;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int OUT_W = 32;
    localparam int BEATS = 128 / OUT_W;
    localparam logic [127:0] K = 128'h0123456789ABCDEFFEDCBA9876543210;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    p2s_out_if #(.OUT_W(OUT_W)) bus();

    p2s_out #(.DEPTH(DEPTH), .AF_THRESH(AF), .OUT_W(OUT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t mon_e;
    int checks = 0, passed = 0;
    int blocks_wr = 0, blocks_done = 0;
    logic prev_hold = 1'b0;
    logic [OUT_W-1:0] prev_d;
    logic prev_l;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // reference model: an accepted block becomes BEATS MSB-first beats, last flag on the final one
    task automatic push_block(input logic [127:0] b);
        logic [127:0] s;
        s = b;
        for (int i = 0; i < BEATS; i++) begin
            exp_q.push_back({s[127 -: OUT_W], 1'(i == BEATS - 1)});
            s = s << OUT_W;
        end
        blocks_wr++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cyc();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) cyc();
    endtask

    // monitor: every transferring beat is popped from the scoreboard; held beats must stay put
    always @(negedge clk) begin
        if (!rst_n) prev_hold = 1'b0;
        else begin
            if (prev_hold)
                chk("hold_stable", {bus.dout_valid, bus.dout_last, bus.dout}, {1'b1, prev_l, prev_d});
            if (bus.dout_valid && !bus.hold_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", bus.dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {bus.dout_last, bus.dout}, {mon_e.l, mon_e.d});
                    if (mon_e.l) blocks_done++;
                end
            end
            prev_hold = bus.dout_valid && bus.hold_o;
            prev_d    = bus.dout;
            prev_l    = bus.dout_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int eo;
        logic [127:0] a, b;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.hold_o    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_last", bus.dout_last, 0);
        chk("rst_af", bus.p2s_fifo_almost_full, 0);
        chk("rst_full", bus.p2s_fifo_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // single block: beats in N+2..N+5, idle at N+6
        bus.din_valid = 1'b1; bus.din = K; push_block(K);
        cyc();
        bus.din_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", bus.dout_valid, 0);
        cyc();
        @(negedge clk);
        chk("lat_n2_valid", bus.dout_valid, 1);
        chk("lat_n2_dout", bus.dout, 32'h01234567);
        repeat (4) cyc();
        @(negedge clk);
        chk("lat_n6_valid", bus.dout_valid, 0);
        wait_drain();

        // hold for 3 cycles while beat 1 is presented
        bus.din_valid = 1'b1; bus.din = K; push_block(K);
        cyc();
        bus.din_valid = 1'b0;
        repeat (2) cyc();
        bus.hold_o = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_beat1", bus.dout, 32'h89ABCDEF);
            cyc();
        end
        bus.hold_o = 1'b0;
        wait_drain();

        // back-to-back blocks: 8 contiguous beats
        a = rnd(); b = rnd();
        bus.din_valid = 1'b1; bus.din = a; push_block(a);
        cyc();
        bus.din = b; push_block(b);
        cyc();
        bus.din_valid = 1'b0;
        for (int i = 0; i < 2 * BEATS; i++) begin
            @(negedge clk);
            chk("b2b_valid", bus.dout_valid, 1);
            chk("b2b_last", bus.dout_last, 1'(i % BEATS == BEATS - 1));
            cyc();
        end
        @(negedge clk);
        chk("b2b_end_valid", bus.dout_valid, 0);
        wait_drain();

        // write coinciding with a pop at occupancy 3
        for (int k = 0; k < 5; k++) begin
            a = rnd();
            bus.din_valid = 1'b1; bus.din = a; push_block(a);
            cyc();
        end
        bus.din_valid = 1'b0;
        repeat (4) cyc();
        a = rnd();
        bus.din_valid = 1'b1; bus.din = a; push_block(a);
        @(negedge clk);
        chk("wp_af_before", bus.p2s_fifo_almost_full, 0);
        chk("wp_full_before", bus.p2s_fifo_full, 0);
        cyc();
        bus.din_valid = 1'b0;
        @(negedge clk);
        chk("wp_af_after", bus.p2s_fifo_almost_full, 0);
        chk("wp_full_after", bus.p2s_fifo_full, 0);
        wait_drain();

        // fill under hold: 9 writes accepted, the 10th dropped
        bus.hold_o = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a = rnd();
            bus.din_valid = 1'b1; bus.din = a;
            if (k < 9) push_block(a);
            eo = (k < 2) ? k : k - 1;
            @(negedge clk);
            chk("fill_af", bus.p2s_fifo_almost_full, 1'(eo >= AF));
            chk("fill_full", bus.p2s_fifo_full, 1'(eo == DEPTH));
            chk("fill_ovf", bus.overflow, 0);
            cyc();
        end
        bus.din_valid = 1'b0;
        @(negedge clk);
        chk("fill_ovf_set", bus.overflow, 1);
        chk("fill_full_set", bus.p2s_fifo_full, 1);
        bus.hold_o = 1'b0;
        cyc();
        wait_drain();
        chk("ovf_sticky", bus.overflow, 1);
        chk("drain_full", bus.p2s_fifo_full, 0);

        // reset pulse during beat 2 with blocks queued
        for (int k = 0; k < 4; k++) begin
            a = rnd();
            bus.din_valid = 1'b1; bus.din = a; push_block(a);
            cyc();
        end
        bus.din_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", bus.dout_valid, 0);
        chk("mrst_dout", bus.dout, 0);
        chk("mrst_last", bus.dout_last, 0);
        chk("mrst_af", bus.p2s_fifo_almost_full, 0);
        chk("mrst_full", bus.p2s_fifo_full, 0);
        chk("mrst_ovf", bus.overflow, 0);
        exp_q.delete();
        blocks_wr = blocks_done;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            chk("post_rst_idle", bus.dout_valid, 0);
        end
        cyc();
        bus.din_valid = 1'b1; bus.din = K; push_block(K);
        cyc();
        bus.din_valid = 1'b0;
        wait_drain();

        // randomized traffic, writes gated so the FIFO never overflows
        for (int i = 0; i < 600; i++) begin
            bus.hold_o = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && blocks_wr - blocks_done < DEPTH) begin
                a = rnd();
                bus.din_valid = 1'b1; bus.din = a; push_block(a);
            end else bus.din_valid = 1'b0;
            cyc();
        end
        bus.din_valid = 1'b0;
        bus.hold_o = 1'b0;
        wait_drain();
        chk("rand_ovf", bus.overflow, 0);
        chk("rand_valid_end", bus.dout_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
